// File: rtl/skein_cmp_pkg.sv
// rtl/skein_cmp_pkg.sv - shared view-select constants and score init helper
package skein_cmp_pkg;

  // Readout selector encodings for view_sel_i
  localparam logic [1:0] VIEW_BEST_TAG   = 2'd0;
  localparam logic [1:0] VIEW_BEST_SCORE = 2'd1;
  localparam logic [1:0] VIEW_LAST_SCORE = 2'd2;
  localparam logic [1:0] VIEW_ACCEPT_CNT = 2'd3;

  // All-ones starting value for a score of width w (w up to 64);
  // callers cast the result down to their own score width.
  function automatic logic [63:0] score_init(input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin single-grant arbiter with rotating priority
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          accept_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o
);

  logic [PW-1:0] ptr;
  int            idx;
  logic          found;

  // Grant the first requesting lane at or after ptr, wrapping around
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = PW'(idx);
      end
    end
  end

  // Move priority to the lane just after the one that was served
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (accept_i) begin
      ptr <= (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + PW'(1);
    end
  end

endmodule

// File: rtl/best_score_tracker.sv
// rtl/best_score_tracker.sv - multi-lane lowest-score tracker with readout mux
module best_score_tracker
  import skein_cmp_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int CHANNELS = 4,
  parameter  int SCORE_W  = 11,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CHANNELS-1:0]     ch_valid_i,
  input  logic [CHANNELS*SCORE_W-1:0] ch_score_i,
  input  logic [CHANNELS*WIDTH-1:0]   ch_tag_i,
  output logic [CHANNELS-1:0]     ch_ready_o,
  input  logic                    clear_i,
  input  logic [1:0]              view_sel_i,
  output logic [WIDTH-1:0]        view_o,
  output logic [SCORE_W-1:0]      best_score_o,
  output logic [WIDTH-1:0]        best_tag_o,
  output logic [CH_W-1:0]         best_channel_o,
  output logic                    improved_o
);

  localparam logic [SCORE_W-1:0] SCORE_INIT = SCORE_W'(score_init(SCORE_W));
  localparam int VW = (WIDTH > SCORE_W) ? WIDTH : SCORE_W;

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     grant_idx;
  logic                accept;
  logic [SCORE_W-1:0]  sel_score;
  logic [WIDTH-1:0]    sel_tag;

  logic                cand_vld;
  logic [SCORE_W-1:0]  cand_score;
  logic [WIDTH-1:0]    cand_tag;
  logic [CH_W-1:0]     cand_ch;

  logic [SCORE_W-1:0]  best_score;
  logic [WIDTH-1:0]    best_tag;
  logic [CH_W-1:0]     best_channel;
  logic                improved;
  logic [SCORE_W-1:0]  last_score;
  logic [WIDTH-1:0]    accept_cnt;
  logic [VW-1:0]       score_ext;

  // While clearing, nothing is offered to the arbiter so no lane is accepted
  assign req        = clear_i ? '0 : ch_valid_i;
  assign accept     = |grant;
  assign ch_ready_o = grant;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Steer the granted lane's score and tag toward the candidate register
  always_comb begin
    sel_score = ch_score_i[int'(grant_idx)*SCORE_W +: SCORE_W];
    sel_tag   = ch_tag_i[int'(grant_idx)*WIDTH +: WIDTH];
  end

  // Candidate stage: capture the accepted entry, drop it on clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_vld   <= 1'b0;
      cand_score <= '0;
      cand_tag   <= '0;
      cand_ch    <= '0;
    end else if (clear_i) begin
      cand_vld <= 1'b0;
    end else begin
      cand_vld <= accept;
      if (accept) begin
        cand_score <= sel_score;
        cand_tag   <= sel_tag;
        cand_ch    <= grant_idx;
      end
    end
  end

  // Compare stage plus bookkeeping; strict less-than so ties keep the older entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_score   <= SCORE_INIT;
      best_tag     <= '0;
      best_channel <= '0;
      improved     <= 1'b0;
      last_score   <= '0;
      accept_cnt   <= '0;
    end else if (clear_i) begin
      best_score   <= SCORE_INIT;
      best_tag     <= '0;
      best_channel <= '0;
      improved     <= 1'b0;
      last_score   <= '0;
      accept_cnt   <= '0;
    end else begin
      improved <= 1'b0;
      if (cand_vld) begin
        last_score <= cand_score;
        if (cand_score < best_score) begin
          best_score   <= cand_score;
          best_tag     <= cand_tag;
          best_channel <= cand_ch;
          improved     <= 1'b1;
        end
      end
      if (accept && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + WIDTH'(1);
      end
    end
  end

  // Readout mux; score fields are zero-extended (or truncated) to WIDTH
  always_comb begin
    view_o    = '0;
    score_ext = '0;
    case (view_sel_i)
      VIEW_BEST_TAG: view_o = best_tag;
      VIEW_BEST_SCORE: begin
        score_ext[SCORE_W-1:0] = best_score;
        view_o = score_ext[WIDTH-1:0];
      end
      VIEW_LAST_SCORE: begin
        score_ext[SCORE_W-1:0] = last_score;
        view_o = score_ext[WIDTH-1:0];
      end
      VIEW_ACCEPT_CNT: view_o = accept_cnt;
      default: view_o = '0;
    endcase
  end

  assign best_score_o   = best_score;
  assign best_tag_o     = best_tag;
  assign best_channel_o = best_channel;
  assign improved_o     = improved;

endmodule

// File: tb/tb_best_score_tracker.sv
// tb/tb_best_score_tracker.sv - scoreboard bench for best_score_tracker
module tb_best_score_tracker;

  localparam int C  = 4;
  localparam int W  = 64;
  localparam int SW = 11;
  localparam logic [SW-1:0] INIT = 11'h7FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni;
  logic [C-1:0]    ch_valid;
  logic [C*SW-1:0] ch_score;
  logic [C*W-1:0]  ch_tag;
  logic [C-1:0]    ch_ready;
  logic            clear;
  logic [1:0]      view_sel;
  logic [W-1:0]    view;
  logic [SW-1:0]   best_score;
  logic [W-1:0]    best_tag;
  logic [1:0]      best_ch;
  logic            improved;

  logic            sat_valid;
  logic [0:0]      sat_ready;
  logic [3:0]      sat_view;
  logic [SW-1:0]   sat_best_score;
  logic [3:0]      sat_best_tag;
  logic [0:0]      sat_best_ch;
  logic            sat_improved;

  // Lane stimulus state: a lane holds its offer until accepted
  logic [C-1:0]    pend;
  logic [SW-1:0]   l_score [C];
  logic [W-1:0]    l_tag [C];

  always_comb begin
    ch_valid = '0;
    ch_score = '0;
    ch_tag   = '0;
    for (int k = 0; k < C; k++) begin
      ch_valid[k]             = pend[k];
      ch_score[k*SW +: SW]    = l_score[k];
      ch_tag[k*W +: W]        = l_tag[k];
    end
  end

  best_score_tracker #(.WIDTH(W), .CHANNELS(C), .SCORE_W(SW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ch_valid_i     (ch_valid),
    .ch_score_i     (ch_score),
    .ch_tag_i       (ch_tag),
    .ch_ready_o     (ch_ready),
    .clear_i        (clear),
    .view_sel_i     (view_sel),
    .view_o         (view),
    .best_score_o   (best_score),
    .best_tag_o     (best_tag),
    .best_channel_o (best_ch),
    .improved_o     (improved)
  );

  best_score_tracker #(.WIDTH(4), .CHANNELS(1), .SCORE_W(SW)) u_sat (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ch_valid_i     (sat_valid),
    .ch_score_i     (11'd100),
    .ch_tag_i       (4'h3),
    .ch_ready_o     (sat_ready),
    .clear_i        (1'b0),
    .view_sel_i     (2'd3),
    .view_o         (sat_view),
    .best_score_o   (sat_best_score),
    .best_tag_o     (sat_best_tag),
    .best_channel_o (sat_best_ch),
    .improved_o     (sat_improved)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  int acc;
  logic [C-1:0] last_ready;

  typedef struct {
    int            cyc;
    logic [SW-1:0] s;
    logic [W-1:0]  t;
    int            ch;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state (behavioural, from the tracking rules)
  int            m_ptr;
  logic [SW-1:0] m_best;
  logic [W-1:0]  m_tag;
  int            m_ch;
  logic [SW-1:0] m_last;
  logic [W-1:0]  m_cnt;
  bit            m_cv;
  logic [SW-1:0] m_cs;
  logic [W-1:0]  m_ct;
  int            m_cc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_best = INIT; m_tag = '0; m_ch = 0; m_last = '0; m_cnt = '0;
    m_cv = 0; m_cs = '0; m_ct = '0; m_cc = 0;
  endtask

  function automatic int model_grant();
    if (clear || !rst_ni) return -1;
    for (int i = 0; i < C; i++) begin
      if (pend[(m_ptr + i) % C]) return (m_ptr + i) % C;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_view(input logic [1:0] s);
    case (s)
      2'd0:    return m_tag;
      2'd1:    return W'(m_best);
      2'd2:    return W'(m_last);
      default: return m_cnt;
    endcase
  endfunction

  // One clock: check outputs mid-cycle, advance the model, then cross the edge
  task automatic step();
    int g;
    @(negedge clk);
    last_ready = ch_ready;
    g = model_grant();
    chk("ready", 64'(ch_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("best_score", 64'(best_score), 64'(m_best));
    chk("best_tag", best_tag, m_tag);
    chk("best_ch", 64'(best_ch), 64'(m_ch));
    chk("view", view, model_view(view_sel));
    acc = -1;
    if (rst_ni) begin
      if (clear) begin
        m_best = INIT; m_tag = '0; m_ch = 0; m_last = '0; m_cnt = '0; m_cv = 0;
      end else begin
        if (m_cv) begin
          m_last = m_cs;
          if (m_cs < m_best) begin
            m_best = m_cs; m_tag = m_ct; m_ch = m_cc;
            exp_q.push_back('{cyc: cyc + 1, s: m_cs, t: m_ct, ch: m_cc});
          end
        end
        if (g >= 0) begin
          m_cv = 1; m_cs = l_score[g]; m_ct = l_tag[g]; m_cc = g;
          if (m_cnt != '1) m_cnt = m_cnt + 1;
          m_ptr = (g + 1) % C;
          acc = g;
        end else begin
          m_cv = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (acc >= 0) pend[acc] = 1'b0;
  endtask

  // Monitor: every improved_o pulse must match the next expected improvement
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("improved_missing", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    if (improved) begin
      pulses = pulses + 1;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        chk("improved_unexpected", 64'd1, 64'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("imp_score", 64'(best_score), 64'(e.s));
        chk("imp_tag", best_tag, e.t);
        chk("imp_ch", 64'(best_ch), 64'(e.ch));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    int sc3[4];
    sc3[0] = 400; sc3[1] = 390; sc3[2] = 390; sc3[3] = 500;
    rst_ni = 1'b0; clear = 1'b0; view_sel = 2'd0; pend = '0; sat_valid = 1'b0;
    for (int k = 0; k < C; k++) begin l_score[k] = '0; l_tag[k] = '0; end
    model_reset();

    // Reset state across every readout
    for (int s = 0; s < 4; s++) begin
      view_sel = 2'(s);
      step();
    end
    chk("reset_best", 64'(best_score), 64'h7FF);
    chk("reset_improved", 64'(improved), 64'd0);
    rst_ni = 1'b1;
    step();

    // Lane 2 alone
    view_sel = 2'd3;
    p0 = pulses;
    pend[2] = 1'b1; l_score[2] = 11'd300; l_tag[2] = 64'hDEAD;
    step();
    chk("t2_ready", 64'(last_ready), 64'b0100);
    step();
    chk("t2_best", 64'(best_score), 64'd300);
    chk("t2_tag", best_tag, 64'hDEAD);
    chk("t2_ch", 64'(best_ch), 64'd2);
    step();
    chk("t2_pulses", 64'(pulses - p0), 64'd1);
    chk("t2_cnt", view, 64'd1);

    // Reset between accept and compare loses the candidate
    pend[0] = 1'b1; l_score[0] = 11'd5; l_tag[0] = 64'h55;
    step();
    rst_ni = 1'b0;
    model_reset();
    step();
    rst_ni = 1'b1;
    p0 = pulses;
    repeat (3) step();
    chk("rst_pulses", 64'(pulses - p0), 64'd0);
    chk("rst_best", 64'(best_score), 64'h7FF);

    // All four lanes continuously busy
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < C; k++) begin
        if (!pend[k]) begin
          pend[k] = 1'b1; l_score[k] = SW'(sc3[k]); l_tag[k] = 64'h100 + 64'(k);
        end
      end
      step();
      chk("t3_grant", 64'(last_ready), 64'd1 << (i % 4));
    end
    repeat (6) step();
    chk("t3_pulses", 64'(pulses - p0), 64'd2);
    chk("t3_best", 64'(best_score), 64'd390);
    chk("t3_ch", 64'(best_ch), 64'd1);

    // Clear drops the in-flight candidate and blocks new offers
    pend[1] = 1'b1; l_score[1] = 11'd10; l_tag[1] = 64'h10;
    step();
    clear = 1'b1;
    pend[2] = 1'b1; l_score[2] = 11'd10; l_tag[2] = 64'h20;
    step();
    clear = 1'b0;
    chk("t4_ready", 64'(last_ready), 64'd0);
    chk("t4_best_a", 64'(best_score), 64'h7FF);
    step();
    chk("t4_best_b", 64'(best_score), 64'h7FF);
    step();
    chk("t4_best_c", 64'(best_score), 64'd10);
    chk("t4_ch_c", 64'(best_ch), 64'd2);

    // Accept counter saturation on a 4-bit, single-lane instance
    sat_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 1) chk("sat_ready", 64'(sat_ready), 64'd1);
      if (i == 14) chk("sat_cnt14", 64'(sat_view), 64'hE);
    end
    chk("sat_cnt17", 64'(sat_view), 64'hF);
    sat_valid = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < C; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          l_score[k] = ($urandom_range(0, 7) == 0) ? INIT : SW'($urandom_range(0, 2046));
          l_tag[k] = {$urandom, $urandom};
        end
      end
      clear = ($urandom_range(0, 15) == 0);
      view_sel = 2'($urandom_range(0, 3));
      step();
    end
    clear = 1'b0;
    repeat (12) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
